// File: rtl/cpht_choice_table_if.sv
// Lookup, prediction and update signals of the tournament choice table.
// master = fetch/resolution side, slave = the table itself.
interface cpht_choice_table_if #(
  parameter int IDX_W = 6
);
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic             p1_pred;
  logic             p2_pred;
  logic             pred_valid;
  logic             pred_taken;
  logic             pred_sel;
  logic [1:0]       pred_state;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_p1_res;
  logic             upd_p2_res;
  logic             init_busy;

  modport master (
    output lookup_valid, lookup_idx, p1_pred, p2_pred,
    output upd_valid, upd_idx, upd_p1_res, upd_p2_res,
    input  pred_valid, pred_taken, pred_sel, pred_state, init_busy
  );

  modport slave (
    input  lookup_valid, lookup_idx, p1_pred, p2_pred,
    input  upd_valid, upd_idx, upd_p1_res, upd_p2_res,
    output pred_valid, pred_taken, pred_sel, pred_state, init_busy
  );
endinterface

// File: rtl/cpht_choice_table.sv
// Choice pattern history table: 2^IDX_W 2-bit counters selecting P1 vs P2,
// cleared by a post-reset sweep, read with 1-cycle latency and trained by RMW.
module cpht_choice_table #(
  parameter int IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  cpht_choice_table_if.slave   bus
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       tbl [DEPTH];

  logic             do_upd;
  logic             do_look;
  logic [1:0]       upd_new;
  logic [1:0]       look_val;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic             pred_sel_q;
  logic [1:0]       pred_state_q;

  // Saturating move toward P1 (00) or P2 (11) when exactly one predictor was right.
  function automatic logic [1:0] train(input logic [1:0] s, input logic p1_ok, input logic p2_ok);
    logic [1:0] r;
    r = s;
    unique case ({p1_ok, p2_ok})
      2'b10:   r = (s == 2'b00) ? 2'b00 : s - 2'b01;
      2'b01:   r = (s == 2'b11) ? 2'b11 : s + 2'b01;
      default: r = s;
    endcase
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == '1) state_d = ST_RUN;
    end
  end

  assign do_upd   = (state_q == ST_RUN) && bus.upd_valid;
  assign do_look  = (state_q == ST_RUN) && bus.lookup_valid;
  assign upd_new  = train(tbl[bus.upd_idx], bus.upd_p1_res, bus.upd_p2_res);
  // A same-index update in this cycle is forwarded so the lookup sees the trained value.
  assign look_val = (do_upd && (bus.upd_idx == bus.lookup_idx)) ? upd_new : tbl[bus.lookup_idx];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: the array has no reset branch; the sweep clears it, keeping it a plain RAM.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state_q == ST_INIT)  tbl[ptr_q]       <= 2'b00;
      else if (do_upd)         tbl[bus.upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_sel_q   <= 1'b0;
      pred_state_q <= 2'b00;
    end else begin
      pred_valid_q <= do_look;
      if (do_look) begin
        pred_state_q <= look_val;
        pred_sel_q   <= look_val[1];
        pred_taken_q <= look_val[1] ? bus.p2_pred : bus.p1_pred;
      end
    end
  end

  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_sel   = pred_sel_q;
  assign bus.pred_state = pred_state_q;
  assign bus.init_busy  = (state_q == ST_INIT);
endmodule

// File: tb/tb_cpht_choice_table.sv
// Bench for cpht_choice_table: directed scenarios plus random traffic checked
// against an integer-array model of the choice counters.
module tb_cpht_choice_table;
  localparam int IDX_W = 6;
  localparam int DEPTH = 1 << IDX_W;

  logic clk;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  int   model [DEPTH];
  int   exp_state;
  int   exp_sel;
  int   exp_taken;

  cpht_choice_table_if #(.IDX_W(IDX_W)) bus ();

  cpht_choice_table #(.IDX_W(IDX_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int trained(input int s, input bit p1_ok, input bit p2_ok);
    if (p1_ok && !p2_ok) return (s > 0) ? s - 1 : 0;
    if (p2_ok && !p1_ok) return (s < 3) ? s + 1 : 3;
    return s;
  endfunction

  task automatic idle();
    bus.lookup_valid = 1'b0;
    bus.lookup_idx   = '0;
    bus.p1_pred      = 1'b0;
    bus.p2_pred      = 1'b0;
    bus.upd_valid    = 1'b0;
    bus.upd_idx      = '0;
    bus.upd_p1_res   = 1'b0;
    bus.upd_p2_res   = 1'b0;
  endtask

  // One RUN-mode cycle: drive, predict from the model, clock, compare.
  task automatic cycle(input bit lv, input int li, input bit p1, input bit p2,
                       input bit uv, input int ui, input bit r1, input bit r2);
    int post;
    bus.lookup_valid = lv;
    bus.lookup_idx   = IDX_W'(li);
    bus.p1_pred      = p1;
    bus.p2_pred      = p2;
    bus.upd_valid    = uv;
    bus.upd_idx      = IDX_W'(ui);
    bus.upd_p1_res   = r1;
    bus.upd_p2_res   = r2;
    if (lv) begin
      post = model[li];
      if (uv && ui == li) post = trained(post, r1, r2);
      exp_state = post;
      exp_sel   = (post >= 2) ? 1 : 0;
      exp_taken = exp_sel ? int'(p2) : int'(p1);
    end
    if (uv) model[ui] = trained(model[ui], r1, r2);
    @(posedge clk); #1;
    check("pred_valid", int'(bus.pred_valid), int'(lv));
    check("pred_state", int'(bus.pred_state), exp_state);
    check("pred_sel",   int'(bus.pred_sel),   exp_sel);
    check("pred_taken", int'(bus.pred_taken), exp_taken);
    idle();
  endtask

  // Bounded wait for the sweep while throwing ignored traffic at the table.
  task automatic run_sweep(input string tag);
    int n;
    n = 0;
    while (bus.init_busy === 1'b1 && n < 200) begin
      bus.lookup_valid = 1'b1;
      bus.lookup_idx   = IDX_W'($urandom);
      bus.p1_pred      = 1'($urandom);
      bus.p2_pred      = 1'($urandom);
      bus.upd_valid    = 1'b1;
      bus.upd_idx      = IDX_W'($urandom);
      bus.upd_p1_res   = 1'b0;
      bus.upd_p2_res   = 1'b1;
      @(posedge clk); #1;
      n++;
      check({tag, "_pv"},    int'(bus.pred_valid), 0);
      check({tag, "_state"}, int'(bus.pred_state), 0);
    end
    idle();
    check({tag, "_len"}, n, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    exp_state = 0;
    exp_sel   = 0;
    exp_taken = 0;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  int'(bus.init_busy),  1);
    check("rst_valid", int'(bus.pred_valid), 0);
    check("rst_taken", int'(bus.pred_taken), 0);
    check("rst_sel",   int'(bus.pred_sel),   0);
    check("rst_state", int'(bus.pred_state), 0);
    resetn = 1'b1;
    run_sweep("init");

    // Every entry reads Strongly_P1 after the sweep.
    for (int i = 0; i < DEPTH; i++) cycle(1, i, 1'($urandom), 1'($urandom), 0, 0, 0, 0);

    cycle(1, 5, 1, 0, 0, 0, 0, 0);
    check("sel_state", int'(bus.pred_state), 0);
    check("sel_taken", int'(bus.pred_taken), 1);

    // Training walk on entry 5.
    repeat (3) cycle(0, 0, 0, 0, 1, 5, 0, 1);
    cycle(1, 5, 1, 0, 0, 0, 0, 0);
    check("walk_s3",     int'(bus.pred_state), 3);
    check("walk_sel",    int'(bus.pred_sel),   1);
    check("walk_taken",  int'(bus.pred_taken), 0);
    cycle(0, 0, 0, 0, 1, 5, 0, 1);
    cycle(1, 5, 0, 1, 0, 0, 0, 0);
    check("walk_sat",    int'(bus.pred_state), 3);
    cycle(0, 0, 0, 0, 1, 5, 1, 0);
    cycle(1, 5, 0, 1, 0, 0, 0, 0);
    check("walk_down",   int'(bus.pred_state), 2);
    cycle(0, 0, 0, 0, 1, 5, 1, 1);
    cycle(0, 0, 0, 0, 1, 5, 0, 0);
    cycle(1, 5, 1, 0, 0, 0, 0, 0);
    check("walk_hold",   int'(bus.pred_state), 2);

    // Same-edge bypass versus an unrelated index.
    cycle(0, 0, 0, 0, 1, 9, 0, 1);
    cycle(1, 9, 0, 1, 1, 9, 0, 1);
    check("byp_same",    int'(bus.pred_state), 2);
    check("byp_sel",     int'(bus.pred_sel),   1);
    cycle(1, 10, 0, 1, 1, 9, 0, 1);
    check("byp_other",   int'(bus.pred_state), 0);

    // Back-to-back lookups.
    repeat (3) cycle(0, 0, 0, 0, 1, 2, 0, 1);
    cycle(1, 1, 1, 1, 0, 0, 0, 0);
    check("pipe_0", int'(bus.pred_state), 0);
    cycle(1, 2, 1, 1, 0, 0, 0, 0);
    check("pipe_1", int'(bus.pred_state), 3);
    cycle(1, 3, 1, 1, 0, 0, 0, 0);
    check("pipe_2", int'(bus.pred_state), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic on a narrow index window to force collisions.
    for (int k = 0; k < 500; k++)
      cycle(1'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));

    // Reset mid-operation after training a few more entries.
    repeat (2) cycle(0, 0, 0, 0, 1, 20, 0, 1);
    cycle(0, 0, 0, 0, 1, 21, 0, 1);
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = IDX_W'(20);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("mid_busy",  int'(bus.init_busy),  1);
    check("mid_valid", int'(bus.pred_valid), 0);
    check("mid_state", int'(bus.pred_state), 0);
    resetn = 1'b1;
    idle();
    run_sweep("resweep");
    cycle(1, 20, 0, 0, 0, 0, 0, 0);
    check("clr_20", int'(bus.pred_state), 0);
    cycle(1, 21, 0, 0, 0, 0, 0, 0);
    check("clr_21", int'(bus.pred_state), 0);
    cycle(1, 5, 0, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0, 0, 0);
    cycle(1, 9, 0, 0, 0, 0, 0, 0);
    check("clr_9", int'(bus.pred_state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
